// File: rtl/scan_shift_ctrl_pkg.sv
// Shared scan-test definitions: controller state encoding and the MISR
// feedback polynomial used by the response compactor.
package scan_shift_ctrl_pkg;

    // Controller states. CKE is only ever high in SHIFT, CAPTURE and UNLOAD.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_UNLOAD  = 3'd4
    } state_e;

    // CCITT polynomial x^16+x^12+x^5+1; narrower signatures take the low bits.
    localparam logic [63:0] MISR_POLY = 64'h0000_0000_0000_1021;

endpackage

// File: rtl/scan_shift_ctrl_if.sv
// Pattern-in / response-out handshake bundle between the test source and the
// scan shift controller. The controller connects through the slave modport.
interface scan_shift_ctrl_if #(
    parameter int CHAIN_LEN = 16
) ();

    logic                 pat_valid;
    logic                 pat_ready;
    logic [CHAIN_LEN-1:0] pat_data;
    logic                 pat_last;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [CHAIN_LEN-1:0] resp_data;

    // Test source side: offers patterns, consumes responses.
    modport master (
        output pat_valid, pat_data, pat_last, resp_ready,
        input  pat_ready, resp_valid, resp_data
    );

    // Controller side.
    modport slave (
        input  pat_valid, pat_data, pat_last, resp_ready,
        output pat_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/scan_shift_ctrl_misr.sv
// Internal-XOR MISR compacting each published scan response into a running
// signature. Responses wider than the signature are folded by XOR-ing
// SIG_W-bit chunks together, the top chunk zero-padded.
module scan_misr
    import scan_shift_ctrl_pkg::*;
#(
    parameter int SIG_W     = 16,
    parameter int CHAIN_LEN = 16
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic                 clr,
    input  logic                 en,
    input  logic [CHAIN_LEN-1:0] data,
    output logic [SIG_W-1:0]     sig
);

    localparam logic [SIG_W-1:0] POLY = MISR_POLY[SIG_W-1:0];
    localparam logic [SIG_W-1:0] ZERO = {SIG_W{1'b0}};

    // Response bit i lands in chunk i/SIG_W at position i%SIG_W.
    function automatic logic [SIG_W-1:0] fold(input logic [CHAIN_LEN-1:0] d);
        logic [SIG_W-1:0] acc;
        acc = ZERO;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            acc[i % SIG_W] = acc[i % SIG_W] ^ d[i];
        end
        return acc;
    endfunction

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic [SIG_W-1:0] fb_s;

    // Next signature: clear wins over an update, otherwise hold.
    always_comb begin
        sig_d = sig_q;
        fb_s  = sig_q[SIG_W-1] ? POLY : ZERO;
        if (clr) begin
            sig_d = ZERO;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ fb_s ^ fold(data);
        end else begin
            sig_d = sig_q;
        end
    end

    // Signature register.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sig_q <= ZERO;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/scan_shift_ctrl.sv
// Scan shift controller: loads patterns serially into a scan chain, applies a
// one-cycle functional capture, and unloads the previous response while the
// next pattern shifts in. The chain clock enable is held low whenever the
// controller waits, so chain contents survive any stall on either handshake.
module scan_shift_ctrl
    import scan_shift_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 16,
    parameter int SIG_W     = 16
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic              start,
    scan_shift_ctrl_if.slave  bus,
    output logic              CKE,
    output logic              SE,
    output logic              SI,
    input  logic              SO,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature
);

    localparam int                   CNT_W    = $clog2(CHAIN_LEN);
    localparam logic [CNT_W-1:0]     CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CHAIN_LEN-1:0] VEC_ZERO = {CHAIN_LEN{1'b0}};

    state_e               state_q, state_d;
    logic [CHAIN_LEN-1:0] sh_q, sh_d;           // pattern out at MSB, SO in at LSB
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 first_q, first_d;     // next shift unloads power-up junk
    logic                 last_q, last_d;       // final pattern already applied
    logic                 resp_valid_q, resp_valid_d;
    logic [CHAIN_LEN-1:0] resp_data_q, resp_data_d;
    logic                 done_q, done_d;
    logic                 cke_q, cke_d;
    logic                 se_q, se_d;
    logic                 si_q, si_d;
    logic                 pat_ready_q, pat_ready_d;
    logic                 busy_q, busy_d;

    logic [CHAIN_LEN-1:0] shift_in_s;
    logic                 misr_clr_s;
    logic                 misr_en_s;

    // Next-state and datapath update for the session sequencer.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        last_d      = last_q;
        resp_data_d = resp_data_q;
        done_d      = 1'b0;
        misr_clr_s  = 1'b0;
        misr_en_s   = 1'b0;
        shift_in_s  = {sh_q[CHAIN_LEN-2:0], SO};

        if (resp_valid_q && bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end else begin
            resp_valid_d = resp_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    misr_clr_s = 1'b1;
                    first_d    = 1'b1;
                    last_d     = 1'b0;
                    state_d    = ST_LOAD;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (last_q) begin
                    // Final response still sits in the chain; unload it once
                    // the previous one has been taken.
                    if (!resp_valid_q) begin
                        cnt_d   = CNT_ZERO;
                        state_d = ST_UNLOAD;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else if (bus.pat_valid && pat_ready_q) begin
                    sh_d    = bus.pat_data;
                    last_d  = bus.pat_last;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SHIFT: begin
                sh_d = shift_in_s;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_CAPTURE;
                    if (first_q) begin
                        first_d = 1'b0;
                    end else begin
                        resp_data_d  = shift_in_s;
                        resp_valid_d = 1'b1;
                        misr_en_s    = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = ST_SHIFT;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_LOAD;
            end
            ST_UNLOAD: begin
                sh_d = shift_in_s;
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = CNT_ZERO;
                    resp_data_d  = shift_in_s;
                    resp_valid_d = 1'b1;
                    misr_en_s    = 1'b1;
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = ST_UNLOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output lookahead: decode the next state so every output comes from a flop
    // and lines up with the state it belongs to.
    always_comb begin
        cke_d       = (state_d == ST_SHIFT) || (state_d == ST_CAPTURE) || (state_d == ST_UNLOAD);
        se_d        = (state_d == ST_SHIFT) || (state_d == ST_UNLOAD);
        si_d        = (state_d == ST_SHIFT) ? sh_d[CHAIN_LEN-1] : 1'b0;
        pat_ready_d = (state_d == ST_LOAD) && !resp_valid_d && !last_d;
        busy_d      = (state_d != ST_IDLE);
    end

    // Controller state and registered outputs.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q      <= ST_IDLE;
            sh_q         <= VEC_ZERO;
            cnt_q        <= CNT_ZERO;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= VEC_ZERO;
            done_q       <= 1'b0;
            cke_q        <= 1'b0;
            se_q         <= 1'b0;
            si_q         <= 1'b0;
            pat_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            last_q       <= last_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            done_q       <= done_d;
            cke_q        <= cke_d;
            se_q         <= se_d;
            si_q         <= si_d;
            pat_ready_q  <= pat_ready_d;
            busy_q       <= busy_d;
        end
    end

    scan_misr #(
        .SIG_W     (SIG_W),
        .CHAIN_LEN (CHAIN_LEN)
    ) u_misr (
        .CLK  (CLK),
        .RN   (RN),
        .clr  (misr_clr_s),
        .en   (misr_en_s),
        .data (resp_data_d),
        .sig  (signature)
    );

    assign bus.pat_ready  = pat_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign CKE            = cke_q;
    assign SE             = se_q;
    assign SI             = si_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_scan_shift_ctrl.sv
// Directed bench for scan_shift_ctrl with a 4-flop chain behind a CKE gate.
// Functional capture of the chain model inverts every flop.
module tb_scan_shift_ctrl;

    localparam int CL = 4;
    localparam int SW = 16;

    logic          CLK = 1'b0;
    logic          RN  = 1'b0;
    logic          start = 1'b0;
    logic          CKE, SE, SI, SO, busy, done;
    logic [SW-1:0] signature;
    logic [CL-1:0] chain = 4'b0000;

    int checks   = 0;
    int failures = 0;

    scan_shift_ctrl_if #(.CHAIN_LEN(CL)) bus ();

    scan_shift_ctrl #(.CHAIN_LEN(CL), .SIG_W(SW)) dut (
        .CLK       (CLK),
        .RN        (RN),
        .start     (start),
        .bus       (bus.slave),
        .CKE       (CKE),
        .SE        (SE),
        .SI        (SI),
        .SO        (SO),
        .busy      (busy),
        .done      (done),
        .signature (signature)
    );

    always #5 CLK = ~CLK;

    // Scan chain model: flop 0 takes SI, flop 3 drives SO.
    assign SO = chain[CL-1];
    always @(posedge CLK) begin
        if (CKE) chain <= SE ? {chain[CL-2:0], SI} : (chain ^ 4'b1111);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_pattern(input logic [CL-1:0] d, input logic last, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        bus.pat_valid = 1'b1;
        bus.pat_data  = d;
        bus.pat_last  = last;
        while (!ok && n < 60) begin
            if (bus.pat_ready === 1'b1) ok = 1'b1;
            tick();
            n++;
        end
        bus.pat_valid = 1'b0;
        bus.pat_last  = 1'b0;
    endtask

    task automatic wait_resp(output logic [CL-1:0] d, output logic dn, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        d  = 4'b0000;
        dn = 1'b0;
        while (!ok && n < 60) begin
            if (bus.resp_valid === 1'b1) begin
                d  = bus.resp_data;
                dn = done;
                ok = 1'b1;
            end else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({busy, CKE, SE, SI, bus.pat_ready, bus.resp_valid, done} !== 7'b0000000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {busy, CKE, SE, SI, bus.pat_ready, bus.resp_valid, done});
        end
        checks++;
        if (bus.resp_data !== 4'b0000 || signature !== 16'h0000) begin
            failures++;
            $display("FAIL reset_data: got %h/%h expected 0/0000", bus.resp_data, signature);
        end
        RN = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b0 || CKE !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b cke=%b expected 0 0", busy, CKE);
        end
    endtask

    task automatic test_single();
        logic [CL-1:0] p;
        logic [CL-1:0] d;
        logic dn;
        bit ok;
        int bad;
        p = 4'b1010;
        bus.resp_ready = 1'b1;
        pulse_start();
        send_pattern(p, 1'b1, ok);
        checks++;
        if (ok !== 1'b1) begin failures++; $display("FAIL single_send: got timeout expected handshake"); end
        bad = 0;
        for (int k = 0; k < CL; k++) begin
            if (SE !== 1'b1 || CKE !== 1'b1 || SI !== p[CL-1-k]) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL single_shift_si: got %0d bad cycles expected 0", bad); end
        checks++;
        if ({CKE, SE, SI} !== 3'b100) begin failures++; $display("FAIL single_capture: got %b expected 100", {CKE, SE, SI}); end
        tick();
        checks++;
        if ({CKE, SE, busy} !== 3'b001) begin failures++; $display("FAIL single_load: got %b expected 001", {CKE, SE, busy}); end
        tick();
        bad = 0;
        for (int k = 0; k < CL; k++) begin
            if ({CKE, SE, SI} !== 3'b110 || bus.resp_valid !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL single_unload: got %0d bad cycles expected 0", bad); end
        wait_resp(d, dn, ok);
        checks++;
        if (ok !== 1'b1 || d !== 4'b0101 || dn !== 1'b1) begin
            failures++;
            $display("FAIL single_resp: got ok=%b data=%b done=%b expected 1 0101 1", ok, d, dn);
        end
        checks++;
        if (signature !== 16'h0005 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_sig: got %h busy=%b expected 0005 0", signature, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || bus.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_done_pulse: got done=%b valid=%b expected 0 0", done, bus.resp_valid);
        end
    endtask

    task automatic test_two_patterns();
        logic [CL-1:0] d;
        logic dn;
        bit ok1, ok2, ok3;
        bus.resp_ready = 1'b1;
        pulse_start();
        send_pattern(4'b0011, 1'b0, ok1);
        send_pattern(4'b1100, 1'b1, ok2);
        checks++;
        if ({ok1, ok2} !== 2'b11) begin failures++; $display("FAIL two_send: got %b expected 11", {ok1, ok2}); end
        wait_resp(d, dn, ok3);
        checks++;
        if (ok3 !== 1'b1 || d !== 4'b1100 || dn !== 1'b0) begin
            failures++;
            $display("FAIL two_resp1: got ok=%b data=%b done=%b expected 1 1100 0", ok3, d, dn);
        end
        tick();
        wait_resp(d, dn, ok3);
        checks++;
        if (ok3 !== 1'b1 || d !== 4'b0011 || dn !== 1'b1) begin
            failures++;
            $display("FAIL two_resp2: got ok=%b data=%b done=%b expected 1 0011 1", ok3, d, dn);
        end
        checks++;
        if (signature !== 16'h001B) begin failures++; $display("FAIL two_sig: got %h expected 001b", signature); end
        tick();
    endtask

    task automatic test_resp_stall();
        logic [CL-1:0] d;
        logic dn;
        bit ok1, ok2, ok3;
        int bad;
        bus.resp_ready = 1'b0;
        pulse_start();
        send_pattern(4'b0011, 1'b0, ok1);
        send_pattern(4'b1100, 1'b1, ok2);
        wait_resp(d, dn, ok3);
        checks++;
        if ({ok1, ok2, ok3} !== 3'b111 || d !== 4'b1100) begin
            failures++;
            $display("FAIL stall_resp1: got ok=%b data=%b expected 111 1100", {ok1, ok2, ok3}, d);
        end
        tick();
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.pat_ready !== 1'b0 || CKE !== 1'b0 || SE !== 1'b0 || bus.resp_valid !== 1'b1 ||
                bus.resp_data !== 4'b1100 || chain !== 4'b0011 || busy !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL stall_hold: got %0d bad cycles expected 0", bad); end
        bus.resp_ready = 1'b1;
        tick();
        wait_resp(d, dn, ok3);
        checks++;
        if (ok3 !== 1'b1 || d !== 4'b0011 || dn !== 1'b1 || signature !== 16'h001B) begin
            failures++;
            $display("FAIL stall_resp2: got ok=%b data=%b done=%b sig=%h expected 1 0011 1 001b", ok3, d, dn, signature);
        end
        tick();
    endtask

    task automatic test_pat_stall();
        logic [CL-1:0] d;
        logic dn;
        bit ok1, ok2, ok3;
        int bad;
        bus.resp_ready = 1'b1;
        pulse_start();
        send_pattern(4'b0110, 1'b0, ok1);
        for (int k = 0; k < CL + 1; k++) tick();
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (CKE !== 1'b0 || SE !== 1'b0 || bus.pat_ready !== 1'b1 || chain !== 4'b1001) bad++;
            tick();
        end
        checks++;
        if (bad !== 0 || ok1 !== 1'b1) begin failures++; $display("FAIL patstall_hold: got %0d bad cycles expected 0", bad); end
        send_pattern(4'b1111, 1'b1, ok2);
        wait_resp(d, dn, ok3);
        checks++;
        if ({ok2, ok3} !== 2'b11 || d !== 4'b1001) begin
            failures++;
            $display("FAIL patstall_resp1: got ok=%b data=%b expected 11 1001", {ok2, ok3}, d);
        end
        tick();
        wait_resp(d, dn, ok3);
        checks++;
        if (ok3 !== 1'b1 || d !== 4'b0000 || dn !== 1'b1 || signature !== 16'h0012) begin
            failures++;
            $display("FAIL patstall_resp2: got ok=%b data=%b done=%b sig=%h expected 1 0000 1 0012", ok3, d, dn, signature);
        end
        tick();
    endtask

    task automatic test_reset_midshift();
        logic [CL-1:0] d;
        logic dn;
        bit ok1, ok2, ok3;
        int bad;
        bus.resp_ready = 1'b1;
        pulse_start();
        send_pattern(4'b0011, 1'b0, ok1);
        send_pattern(4'b0101, 1'b0, ok2);
        wait_resp(d, dn, ok3);
        tick();
        send_pattern(4'b1100, 1'b1, ok1);
        tick();
        tick();
        checks++;
        if ({ok1, ok2, ok3} !== 3'b111 || signature !== 16'h000C || bus.resp_data !== 4'b1100 || SE !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: got ok=%b sig=%h data=%b se=%b expected 111 000c 1100 1", {ok1, ok2, ok3}, signature, bus.resp_data, SE);
        end
        RN = 1'b0;
        #1;
        checks++;
        if ({busy, CKE, SE, SI, bus.pat_ready, bus.resp_valid, done} !== 7'b0000000 ||
            bus.resp_data !== 4'b0000 || signature !== 16'h0000) begin
            failures++;
            $display("FAIL midrst_async: got ctrl=%b data=%b sig=%h expected 0000000 0000 0000",
                     {busy, CKE, SE, SI, bus.pat_ready, bus.resp_valid, done}, bus.resp_data, signature);
        end
        tick();
        tick();
        RN = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (busy !== 1'b0 || bus.resp_valid !== 1'b0 || done !== 1'b0 || CKE !== 1'b0 || SE !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL midrst_quiet: got %0d bad cycles expected 0", bad); end
        pulse_start();
        send_pattern(4'b1010, 1'b1, ok1);
        wait_resp(d, dn, ok3);
        checks++;
        if ({ok1, ok3} !== 2'b11 || d !== 4'b0101 || dn !== 1'b1 || signature !== 16'h0005) begin
            failures++;
            $display("FAIL midrst_clean: got ok=%b data=%b done=%b sig=%h expected 11 0101 1 0005", {ok1, ok3}, d, dn, signature);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        logic [CL-1:0] d;
        logic dn;
        bit ok1, ok2, ok3;
        bus.resp_ready = 1'b1;
        pulse_start();
        send_pattern(4'b0011, 1'b0, ok1);
        send_pattern(4'b1100, 1'b1, ok2);
        wait_resp(d, dn, ok3);
        checks++;
        if ({ok1, ok2, ok3} !== 3'b111 || d !== 4'b1100 || signature !== 16'h000C) begin
            failures++;
            $display("FAIL busy_resp1: got ok=%b data=%b sig=%h expected 111 1100 000c", {ok1, ok2, ok3}, d, signature);
        end
        pulse_start();
        checks++;
        if (busy !== 1'b1 || signature !== 16'h000C) begin
            failures++;
            $display("FAIL busy_start_ignored: got busy=%b sig=%h expected 1 000c", busy, signature);
        end
        wait_resp(d, dn, ok3);
        checks++;
        if (ok3 !== 1'b1 || d !== 4'b0011 || dn !== 1'b1 || signature !== 16'h001B) begin
            failures++;
            $display("FAIL busy_resp2: got ok=%b data=%b done=%b sig=%h expected 1 0011 1 001b", ok3, d, dn, signature);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || CKE !== 1'b0) begin
            failures++;
            $display("FAIL busy_end_idle: got busy=%b cke=%b expected 0 0", busy, CKE);
        end
    endtask

    initial begin
        bus.pat_valid  = 1'b0;
        bus.pat_data   = 4'b0000;
        bus.pat_last   = 1'b0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_single();
        test_two_patterns();
        test_resp_stall();
        test_pat_stall();
        test_reset_midshift();
        test_start_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_shift_ctrl.md
SCAN_SHIFT_CTRL -- requirements
Module: scan_shift_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 16: number of scan flops in the driven chain (legal 2..64).
REQ-002 SHALL have parameter SIG_W, default 16: response signature (MISR) width.
REQ-003 SHALL have one clock and asynchronous active-low reset: CLK input 1 rising-edge clock; RN input 1 asynchronous active-low reset.
REQ-004 SHALL have: start input 1, one-cycle pulse, begins a test session.
REQ-005 SHALL have: pat_valid input 1; pat_ready output 1; pat_data input CHAIN_LEN, pattern, bit j loads chain flop j; pat_last input 1, final pattern of session.
REQ-006 SHALL have: CKE output 1, chain clock enable to the chain clock gate; SE output 1, scan enable; SI output 1, serial data into chain flop 0; SO input 1, serial data from chain flop CHAIN_LEN-1.
REQ-007 SHALL have: resp_valid output 1; resp_ready input 1; resp_data output CHAIN_LEN, captured response, bit j from chain flop j.
REQ-008 SHALL have: busy output 1; done output 1, one-cycle pulse; signature output SIG_W.

Function
REQ-009 States SHALL be IDLE, LOAD, SHIFT, CAPTURE, UNLOAD.
REQ-010 IDLE: CKE=0, SE=0, pat_ready=0; start -> clear signature, set first flag, clear last flag, go LOAD; start SHALL be ignored outside IDLE.
REQ-011 LOAD: CKE=0; pat_ready = !resp_valid && !last flag; handshake (pat_valid&&pat_ready) latches pat_data into the shift register, latches pat_last into the last flag, zeroes the counter, goes SHIFT.
REQ-012 LOAD with last flag set and resp_valid=0 SHALL go UNLOAD with counter zeroed.
REQ-013 SHIFT: CKE=1, SE=1, exactly CHAIN_LEN cycles; cycle k drives SI = pattern bit CHAIN_LEN-1-k and samples SO into response bit CHAIN_LEN-1-k.
REQ-014 At SHIFT cycle CHAIN_LEN-1: if first flag set, the sampled response SHALL be discarded and first flag cleared; otherwise resp_data loads the response and resp_valid sets the next cycle; then go CAPTURE.
REQ-015 CAPTURE: CKE=1, SE=0, SI=0 for exactly one cycle, then LOAD.
REQ-016 UNLOAD: CKE=1, SE=1, SI=0 for CHAIN_LEN cycles, sampling SO as in SHIFT; at the final cycle publish response (resp_valid), pulse done the following cycle, go IDLE.
REQ-017 CKE SHALL be 0 in IDLE and LOAD so chain contents are frozen across any stall; no state other than CAPTURE drives SE=0 with CKE=1.
REQ-018 resp_valid SHALL hold with resp_data stable until resp_valid&&resp_ready; the accepting edge clears it; a new response never overwrites an unaccepted one (guaranteed by REQ-011/012).
REQ-019 Each published response SHALL update signature as an internal-XOR MISR: next = {sig[SIG_W-2:0],0} XOR (sig[SIG_W-1] ? 0x1021 (low SIG_W bits) : 0) XOR fold(resp_data), fold = XOR of resp_data split into SIG_W-bit chunks, last chunk zero-padded.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 Session with a single pattern with pat_last=1: SHIFT (response discarded), CAPTURE, UNLOAD, exactly one response.
REQ-022 Counter SHALL be ceil(log2(CHAIN_LEN)) bits and never wraps past CHAIN_LEN-1.

Reset
REQ-023 RN low SHALL asynchronously force IDLE, CKE=0, SE=0, SI=0, pat_ready=0, resp_valid=0, resp_data=0, busy=0, done=0, signature=0, flags and counter 0.
REQ-024 Reset mid-session SHALL abandon the session; no response or done is produced after release until a new start.

Structure
REQ-025 State enumeration and the MISR polynomial constant SHALL live in a shared scan-test package.
REQ-026 The MISR SHALL be a sub-module scan_misr (parameter SIG_W, CHAIN_LEN; inputs CLK, RN, clr, en, data; output sig); all else in one module.

Verification (CHAIN_LEN=4, SIG_W=16, bench models a 4-flop scan chain behind a CKE clock gate with functional capture value = pattern XOR 4'b1111)
REQ-027 start; pattern 4'b1010 pat_last=1, resp_ready=1 -> SI sequence 1,0,1,0 over 4 SE=1 cycles; one SE=0 cycle; unload gives resp_data=4'b0101; done one cycle later.
REQ-028 Patterns 4'b0011, 4'b1100 (last) -> responses 4'b1100 then 4'b0011 in order; signature after = MISR of those two words from 0.
REQ-029 resp_ready held 0 for 20 cycles after first response -> pat_ready=0, CKE=0 throughout; chain contents unchanged; resume produces correct second response.
REQ-030 pat_valid withheld 10 cycles in LOAD -> CKE=0, SE=0 throughout, no chain corruption.
REQ-031 RN asserted during SHIFT cycle 2 -> all outputs at reset values immediately; start after release runs a clean session.
REQ-032 start pulsed while busy -> ignored; signature not cleared.
